tof_frame_pack: RTL and testbench

Downstream stage of the TOF calculator. It takes the single-cycle `out_valid`/`tof_data_in` results of one measurement and discards the start-marker result. It collects up to three stop results, pads missing stops with the no-hit code, and emits the measurement as a frame of words over a valid/ready stream to the readout interface.

---
 rtl/tof_frame_pack_pkg.sv | 18 +
 rtl/tof_slot_buf.sv | 60 ++++++
 rtl/tof_frame_pack.sv | 163 ++++++++++++++++
 tb/tb_tof_frame_pack.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tof_frame_pack_pkg.sv
// Shared types and constants for the TOF frame packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tof_frame_pack_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_EMIT    = 2'd2
   } state_t;

   localparam int TW = 15;
   localparam logic [TW-1:0] NOHIT = 15'h7FFF;

   // Output word layout: {last, tof[14:0]}
   localparam int LAST_BIT = 15;

endpackage

// File: rtl/tof_slot_buf.sv
// Stop-result register file with one write port and a pad-from-index fill port.
// Latency: writes land next cycle; rd_data shows the post-write value combinationally.
// Backpressure: none; the owner decides when to write or pad.
module tof_slot_buf #(
   parameter int NUM_MAX = 3,
   parameter int TW = tof_frame_pack_pkg::TW,
   parameter logic [TW-1:0] NOHIT = tof_frame_pack_pkg::NOHIT,
   localparam int IW = $clog2(NUM_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_idx,
   input  logic [TW-1:0] wr_data,
   input  logic          pad_en,
   input  logic [IW-1:0] pad_from,
   input  logic [IW-1:0] pad_to,
   input  logic [IW-1:0] rd_idx,
   output logic [TW-1:0] rd_data
);

   logic [TW-1:0] slot_q [NUM_MAX];
   logic [TW-1:0] slot_d [NUM_MAX];

   // Next contents: a write wins its slot, padding covers the rest of [pad_from, pad_to)
   always_comb begin
      for (int i = 0; i < NUM_MAX; i++) begin
         slot_d[i] = slot_q[i];
         if (wr_en && (wr_idx == IW'(i))) begin
            slot_d[i] = wr_data;
         end else if (pad_en && (IW'(i) >= pad_from) && (IW'(i) < pad_to)) begin
            slot_d[i] = NOHIT;
         end
      end
   end

   // Slot storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_MAX; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_MAX; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   // Read the post-write view so the stream register can load word 0 on the closing cycle
   always_comb begin
      rd_data = NOHIT;
      for (int i = 0; i < NUM_MAX; i++) begin
         if (rd_idx == IW'(i)) begin
            rd_data = slot_d[i];
         end
      end
   end

endmodule

// File: rtl/tof_frame_pack.sv
// Collects up to NUM_MAX stop results per measurement and streams them as a padded frame.
// Latency: word 0 valid the cycle after meas_end; one word per cycle with out_ready high.
// Backpressure: out_valid/out_data hold until out_ready; new windows are refused while busy.
module tof_frame_pack #(
   parameter int NUM_MAX = 3,
   parameter int TW = tof_frame_pack_pkg::TW,
   parameter logic [TW-1:0] NOHIT = tof_frame_pack_pkg::NOHIT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tof_valid,
   input  logic [TW-1:0] tof_data,
   input  logic          meas_start,
   input  logic          meas_end,
   input  logic [1:0]    TDC_Onum,
   output logic [TW:0]   out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          frame_drop,
   output logic [1:0]    extra_hits
);

   import tof_frame_pack_pkg::*;

   localparam int IW = $clog2(NUM_MAX + 1);

   state_t        state_q, state_d;
   logic [IW-1:0] onum_q;
   logic [IW-1:0] idx_q;
   logic [IW-1:0] wp_q;
   logic          skip_q;

   logic          accept, reject;
   logic          hit, store, surplus, pad;
   logic          hs, last_hs;
   logic [IW-1:0] onum_new;
   logic [IW-1:0] rd_idx;
   logic [TW-1:0] rd_data;

   assign accept  = (state_q == ST_IDLE) && meas_start;
   assign reject  = (state_q != ST_IDLE) && meas_start;
   assign hit     = (state_q == ST_COLLECT) && tof_valid;
   assign store   = hit && !skip_q && (idx_q < onum_q);
   assign surplus = hit && !skip_q && (idx_q >= onum_q);
   assign pad     = (state_q == ST_COLLECT) && meas_end;
   assign hs      = (state_q == ST_EMIT) && out_valid && out_ready;
   assign last_hs = hs && out_data[LAST_BIT];

   // In EMIT look one word ahead so the stream register can reload on each handshake
   assign rd_idx  = (state_q == ST_EMIT) ? (wp_q + IW'(1)) : '0;

   // Requested stop count: zero still reports one word, and never more than the buffer holds
   always_comb begin
      onum_new = IW'(TDC_Onum);
      if (TDC_Onum == 2'd0) begin
         onum_new = IW'(1);
      end else if (int'(TDC_Onum) > NUM_MAX) begin
         onum_new = IW'(NUM_MAX);
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (accept)  state_d = ST_COLLECT;
         ST_COLLECT: if (pad)     state_d = ST_EMIT;
         ST_EMIT:    if (last_hs) state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   // Per-measurement bookkeeping: stop count, hit index, start-marker skip, surplus count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         onum_q     <= IW'(1);
         idx_q      <= '0;
         skip_q     <= 1'b1;
         extra_hits <= 2'd0;
      end else if (accept) begin
         onum_q     <= onum_new;
         idx_q      <= '0;
         skip_q     <= 1'b1;
         extra_hits <= 2'd0;
      end else begin
         if (hit && skip_q) begin
            skip_q <= 1'b0;
         end
         if (store) begin
            idx_q <= idx_q + IW'(1);
         end
         if (surplus && (extra_hits != 2'd3)) begin
            extra_hits <= extra_hits + 2'd1;
         end
      end
   end

   // Word pointer of the word currently presented on the stream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q <= '0;
      end else if (pad) begin
         wp_q <= '0;
      end else if (hs) begin
         wp_q <= wp_q + IW'(1);
      end
   end

   // Stream output register: loads word 0 on window close, advances only on handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (pad) begin
         out_valid <= 1'b1;
         out_data  <= {(onum_q == IW'(1)), rd_data};
      end else if (last_hs) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (hs) begin
         out_data  <= {((wp_q + IW'(1)) == (onum_q - IW'(1))), rd_data};
      end
   end

   // Registered status: busy follows the next state, frame_drop flags refused windows
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= 1'b0;
         frame_drop <= 1'b0;
      end else begin
         busy       <= (state_d != ST_IDLE);
         frame_drop <= reject;
      end
   end

   tof_slot_buf #(
      .NUM_MAX (NUM_MAX),
      .TW      (TW),
      .NOHIT   (NOHIT)
   ) u_slot_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (store),
      .wr_idx   (idx_q),
      .wr_data  (tof_data),
      .pad_en   (pad),
      .pad_from (idx_q),
      .pad_to   (onum_q),
      .rd_idx   (rd_idx),
      .rd_data  (rd_data)
   );

endmodule

// File: tb/tb_tof_frame_pack.sv
// Directed bench for tof_frame_pack: framing, padding, surplus stops, backpressure, reset.
// Latency: inputs change #1 after posedge; outputs sampled #1 after posedge.
// Backpressure: out_ready driven per scenario.
module tb_tof_frame_pack;

   logic        clk;
   logic        rst_n;
   logic        tof_valid;
   logic [14:0] tof_data;
   logic        meas_start;
   logic        meas_end;
   logic [1:0]  TDC_Onum;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        frame_drop;
   logic [1:0]  extra_hits;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] got [8];
   int          got_n;

   tof_frame_pack dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tof_valid  (tof_valid),
      .tof_data   (tof_data),
      .meas_start (meas_start),
      .meas_end   (meas_end),
      .TDC_Onum   (TDC_Onum),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .frame_drop (frame_drop),
      .extra_hits (extra_hits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_meas(input logic [1:0] n);
      TDC_Onum   = n;
      meas_start = 1'b1;
      tick();
      meas_start = 1'b0;
   endtask

   task automatic hit(input logic [14:0] v);
      tof_valid = 1'b1;
      tof_data  = v;
      tick();
      tof_valid = 1'b0;
   endtask

   task automatic end_meas();
      meas_end = 1'b1;
      tick();
      meas_end = 1'b0;
   endtask

   // Collects words with out_ready high until out_valid drops (bounded)
   task automatic drain();
      got_n     = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 8 && out_valid; k++) begin
         got[got_n] = out_data;
         got_n++;
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (frame_drop !== 1'b0) begin failures++; $display("FAIL reset_frame_drop got=%b want=0", frame_drop); end
      checks++; if (extra_hits !== 2'd0) begin failures++; $display("FAIL reset_extra_hits got=%0d want=0", extra_hits); end
      rst_n = 1'b1;
      tick();
      // tof_valid and meas_end in IDLE must not start anything
      tof_valid = 1'b1; tof_data = 15'h0777; meas_end = 1'b1;
      tick();
      tof_valid = 1'b0; meas_end = 1'b0;
      tick();
      checks++; if ({busy, out_valid} !== 2'b00) begin failures++; $display("FAIL idle_ignore got busy,valid=%b want=00", {busy, out_valid}); end
   endtask

   task automatic test_fill_onum2();
      start_meas(2'd2);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fill_busy got=%b want=1", busy); end
      hit(15'h0123);
      hit(15'h0400);
      hit(15'h0515);
      end_meas();
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h0400) begin failures++; $display("FAIL fill_word0_latency got valid=%b data=%h want 1/0400", out_valid, out_data); end
      drain();
      checks++; if (got_n !== 2) begin failures++; $display("FAIL fill_count got=%0d want=2", got_n); end
      checks++; if (got[0] !== 16'h0400) begin failures++; $display("FAIL fill_w0 got=%h want=0400", got[0]); end
      checks++; if (got[1] !== 16'h8515) begin failures++; $display("FAIL fill_w1 got=%h want=8515", got[1]); end
      checks++; if (extra_hits !== 2'd0) begin failures++; $display("FAIL fill_extra got=%0d want=0", extra_hits); end
      checks++; if ({busy, out_valid} !== 2'b00) begin failures++; $display("FAIL fill_idle got busy,valid=%b want=00", {busy, out_valid}); end
   endtask

   task automatic test_pad_onum3();
      start_meas(2'd3);
      hit(15'h0123);
      hit(15'h0040);
      end_meas();
      drain();
      checks++; if (got_n !== 3) begin failures++; $display("FAIL pad_count got=%0d want=3", got_n); end
      checks++; if (got[0] !== 16'h0040) begin failures++; $display("FAIL pad_w0 got=%h want=0040", got[0]); end
      checks++; if (got[1] !== 16'h7FFF) begin failures++; $display("FAIL pad_w1 got=%h want=7fff", got[1]); end
      checks++; if (got[2] !== 16'hFFFF) begin failures++; $display("FAIL pad_w2 got=%h want=ffff", got[2]); end
   endtask

   task automatic test_onum0_surplus();
      start_meas(2'd0);
      hit(15'h0123);
      hit(15'h0011);
      hit(15'h0022);
      hit(15'h0033);
      hit(15'h0044);
      hit(15'h0055);
      end_meas();
      drain();
      checks++; if (got_n !== 1) begin failures++; $display("FAIL onum0_count got=%0d want=1", got_n); end
      checks++; if (got[0] !== 16'h8011) begin failures++; $display("FAIL onum0_w0 got=%h want=8011", got[0]); end
      checks++; if (extra_hits !== 2'd3) begin failures++; $display("FAIL onum0_extra got=%0d want=3", extra_hits); end
   endtask

   task automatic test_same_cycle();
      start_meas(2'd2);
      checks++; if (extra_hits !== 2'd0) begin failures++; $display("FAIL extra_clear_on_start got=%0d want=0", extra_hits); end
      hit(15'h0123);
      tof_valid = 1'b1; tof_data = 15'h0100; meas_end = 1'b1;
      tick();
      tof_valid = 1'b0; meas_end = 1'b0;
      drain();
      checks++; if (got_n !== 2) begin failures++; $display("FAIL same_count got=%0d want=2", got_n); end
      checks++; if (got[0] !== 16'h0100) begin failures++; $display("FAIL same_w0 got=%h want=0100", got[0]); end
      checks++; if (got[1] !== 16'hFFFF) begin failures++; $display("FAIL same_w1 got=%h want=ffff", got[1]); end
   endtask

   task automatic test_backpressure();
      int drops;
      start_meas(2'd3);
      hit(15'h0123);
      hit(15'h0A01);
      hit(15'h0A02);
      hit(15'h0A03);
      end_meas();
      out_ready = 1'b0;
      drops = 0;
      for (int i = 0; i < 5; i++) begin
         TDC_Onum   = 2'd1;
         meas_start = (i == 1);
         tick();
         meas_start = 1'b0;
         if (frame_drop === 1'b1) drops++;
         checks++; if (out_valid !== 1'b1 || out_data !== 16'h0A01) begin failures++; $display("FAIL stall_hold[%0d] got valid=%b data=%h want 1/0a01", i, out_valid, out_data); end
      end
      checks++; if (drops !== 1) begin failures++; $display("FAIL stall_frame_drop got=%0d pulses want=1", drops); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_data !== 16'h0A02) begin failures++; $display("FAIL bp_w1 got=%h want=0a02", out_data); end
      tick();
      checks++; if (out_data !== 16'h8A03) begin failures++; $display("FAIL bp_w2 got=%h want=8a03", out_data); end
      // start during the final handshake is refused
      TDC_Onum = 2'd2; meas_start = 1'b1;
      tick();
      meas_start = 1'b0; out_ready = 1'b0;
      checks++; if (frame_drop !== 1'b1) begin failures++; $display("FAIL last_hs_start_drop got=%b want=1", frame_drop); end
      checks++; if ({busy, out_valid} !== 2'b00) begin failures++; $display("FAIL bp_done got busy,valid=%b want=00", {busy, out_valid}); end
      // start right after the final handshake is accepted
      meas_start = 1'b1;
      tick();
      meas_start = 1'b0;
      checks++; if ({busy, frame_drop} !== 2'b10) begin failures++; $display("FAIL post_hs_start got busy,drop=%b want=10", {busy, frame_drop}); end
   endtask

   // Continues the measurement opened (onum 2) at the end of test_backpressure
   task automatic test_reset_mid_emit();
      hit(15'h0123);
      hit(15'h0B01);
      hit(15'h0B02);
      end_meas();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_data !== 16'h8B02) begin failures++; $display("FAIL rst_pre_w1 got=%h want=8b02", out_data); end
      rst_n = 1'b0;
      #1;
      checks++; if ({out_valid, busy, frame_drop, extra_hits, out_data} !== 21'd0) begin failures++; $display("FAIL rst_mid_outputs got valid=%b busy=%b drop=%b extra=%0d data=%h want all 0", out_valid, busy, frame_drop, extra_hits, out_data); end
      tick();
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_no_residue[%0d] got valid=%b want=0", i, out_valid); end
      end
      out_ready = 1'b0;
      start_meas(2'd1);
      hit(15'h0123);
      hit(15'h0C0C);
      end_meas();
      drain();
      checks++; if (got_n !== 1) begin failures++; $display("FAIL rst_after_count got=%0d want=1", got_n); end
      checks++; if (got[0] !== 16'h8C0C) begin failures++; $display("FAIL rst_after_w0 got=%h want=8c0c", got[0]); end
   endtask

   initial begin
      rst_n      = 1'b0;
      tof_valid  = 1'b0;
      tof_data   = '0;
      meas_start = 1'b0;
      meas_end   = 1'b0;
      TDC_Onum   = 2'd0;
      out_ready  = 1'b0;
      got_n      = 0;
      for (int i = 0; i < 8; i++) got[i] = '0;

      test_reset();
      test_fill_onum2();
      test_pad_onum3();
      test_onum0_surplus();
      test_same_cycle();
      test_backpressure();
      test_reset_mid_emit();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
